// File: rtl/fnn_argmax_scheduler_if.sv
// Signal bundle linking the output layer, the max_finder datapath and the
// result consumer to fnn_argmax_scheduler.
interface fnn_argmax_scheduler_if #(
  parameter int INDATA_WIDTH = 47
);
  logic                    wr_en;
  logic [3:0]              wr_addr;
  logic [INDATA_WIDTH-1:0] wr_data;
  logic                    layer_done;
  logic                    busy;
  logic                    mf_reset_allowed;
  logic                    mf_start;
  logic [INDATA_WIDTH-1:0] mf_data;
  logic                    mf_found;
  logic [3:0]              mf_index;
  logic                    result_valid;
  logic [3:0]              result_class;
  logic                    result_ready;
  logic [15:0]             frame_count;
  logic                    error;

  modport master (
    output wr_en, wr_addr, wr_data, layer_done, mf_found, mf_index, result_ready,
    input  busy, mf_reset_allowed, mf_start, mf_data, result_valid, result_class,
           frame_count, error
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, layer_done, mf_found, mf_index, result_ready,
    output busy, mf_reset_allowed, mf_start, mf_data, result_valid, result_class,
           frame_count, error
  );
endinterface

// File: rtl/fnn_argmax_scheduler.sv
// Buffers one frame of output-layer values, streams it into max_finder and
// hands the winning class downstream over a valid/ready handshake.
module fnn_argmax_scheduler #(
  parameter int INDATA_WIDTH   = 47,
  parameter int NN4            = 10,
  parameter int TIMEOUT_CYCLES = 4
) (
  input logic                   clk,
  input logic                   reset,
  fnn_argmax_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [4:0]  NN4_W        = 5'(NN4);
  localparam logic [3:0]  LAST_PTR     = 4'(NN4 - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                  state_r;
  logic [3:0]              ptr_r;
  logic [15:0]             wait_cnt_r;
  logic [NN4-1:0]          mask_r;
  logic [INDATA_WIDTH-1:0] buf_r [NN4];

  logic                    busy_r;
  logic                    mf_reset_allowed_r;
  logic                    mf_start_r;
  logic [INDATA_WIDTH-1:0] mf_data_r;
  logic                    result_valid_r;
  logic [3:0]              result_class_r;
  logic [15:0]             frame_count_r;
  logic                    error_r;

  logic                    wr_hit_s;
  logic [NN4-1:0]          mask_next_s;

  // Accepted write strobe and the mask including it, so a write in the
  // layer_done cycle counts toward completeness.
  always_comb begin
    wr_hit_s    = 1'b0;
    mask_next_s = mask_r;
    if ((state_r == IDLE) && bus.wr_en && ({1'b0, bus.wr_addr} < NN4_W)) begin
      wr_hit_s                 = 1'b1;
      mask_next_s[bus.wr_addr] = 1'b1;
    end else begin
      wr_hit_s = 1'b0;
    end
  end

  // Value buffer; deliberately not reset, validity is tracked by mask_r.
  always_ff @(posedge clk) begin
    if (wr_hit_s) begin
      buf_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Sequencer with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r            <= IDLE;
      ptr_r              <= 4'd0;
      wait_cnt_r         <= 16'd0;
      mask_r             <= {NN4{1'b0}};
      busy_r             <= 1'b0;
      mf_reset_allowed_r <= 1'b0;
      mf_start_r         <= 1'b0;
      mf_data_r          <= {INDATA_WIDTH{1'b0}};
      result_valid_r     <= 1'b0;
      result_class_r     <= 4'd0;
      frame_count_r      <= 16'd0;
      error_r            <= 1'b0;
    end else begin
      error_r <= 1'b0;
      case (state_r)
        IDLE: begin
          mask_r <= mask_next_s;
          if (bus.layer_done) begin
            if (&mask_next_s) begin
              state_r            <= CLEAR;
              busy_r             <= 1'b1;
              mf_reset_allowed_r <= 1'b1;
            end else begin
              error_r <= 1'b1;
              mask_r  <= {NN4{1'b0}};
            end
          end
        end
        CLEAR: begin
          state_r            <= STREAM;
          mf_reset_allowed_r <= 1'b0;
          mf_start_r         <= 1'b1;
          ptr_r              <= 4'd0;
          mf_data_r          <= buf_r[0];
        end
        STREAM: begin
          if (ptr_r == LAST_PTR) begin
            state_r    <= WAIT;
            mf_start_r <= 1'b0;
            wait_cnt_r <= 16'd0;
          end else begin
            ptr_r     <= ptr_r + 4'd1;
            mf_data_r <= buf_r[ptr_r + 4'd1];
          end
        end
        WAIT: begin
          if (bus.mf_found) begin
            state_r        <= DONE;
            result_class_r <= bus.mf_index;
            result_valid_r <= 1'b1;
          end else if (wait_cnt_r == TIMEOUT_LAST) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            error_r <= 1'b1;
            mask_r  <= {NN4{1'b0}};
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        DONE: begin
          if (bus.result_ready) begin
            state_r        <= IDLE;
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
            frame_count_r  <= frame_count_r + 16'd1;
            mask_r         <= {NN4{1'b0}};
          end
        end
        default: begin
          state_r            <= IDLE;
          busy_r             <= 1'b0;
          mf_reset_allowed_r <= 1'b0;
          mf_start_r         <= 1'b0;
          result_valid_r     <= 1'b0;
          mask_r             <= {NN4{1'b0}};
        end
      endcase
    end
  end

  assign bus.busy             = busy_r;
  assign bus.mf_reset_allowed = mf_reset_allowed_r;
  assign bus.mf_start         = mf_start_r;
  assign bus.mf_data          = mf_data_r;
  assign bus.result_valid     = result_valid_r;
  assign bus.result_class     = result_class_r;
  assign bus.frame_count      = frame_count_r;
  assign bus.error            = error_r;

endmodule

// File: tb/tb_fnn_argmax_scheduler.sv
// Directed bench for fnn_argmax_scheduler with a behavioural max_finder that
// samples on the falling edge.
module tb_fnn_argmax_scheduler;

  localparam int W   = 47;
  localparam int NN4 = 10;

  logic clk;
  logic reset;
  bit   mf_tie_low;
  logic [W-1:0] mf_max;
  int   mf_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  fnn_argmax_scheduler_if #(.INDATA_WIDTH(W)) bus ();

  fnn_argmax_scheduler #(
    .INDATA_WIDTH  (W),
    .NN4           (NN4),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Nominal max_finder: cleared by mf_reset_allowed, first maximum wins.
  always @(negedge clk) begin
    if (reset || bus.mf_reset_allowed) begin
      mf_cnt        = 0;
      mf_max        = '0;
      bus.mf_found  = 1'b0;
      bus.mf_index  = 4'd0;
    end else if (bus.mf_start) begin
      if (mf_cnt == 0 || bus.mf_data > mf_max) begin
        mf_max       = bus.mf_data;
        bus.mf_index = 4'(mf_cnt);
      end
      mf_cnt = mf_cnt + 1;
      if (mf_cnt == NN4 && !mf_tie_low) bus.mf_found = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int addr, input logic [W-1:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'(addr);
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic write_frame(input logic [W-1:0] v [NN4], input int count);
    for (int i = 0; i < count; i++) write_word(i, v[i]);
  endtask

  task automatic pulse_done();
    bus.layer_done = 1'b1;
    tick();
    bus.layer_done = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int start_n, input int exp_n);
    int n;
    n = start_n;
    while (!bus.result_valid && n < 60) begin
      tick();
      n++;
    end
    check_eq(tag, 64'(n), 64'(exp_n));
  endtask

  task automatic handshake();
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"},  64'(bus.busy), 64'd0);
    check_eq({tag, "_mfra"},  64'(bus.mf_reset_allowed), 64'd0);
    check_eq({tag, "_start"}, 64'(bus.mf_start), 64'd0);
    check_eq({tag, "_data"},  64'(bus.mf_data), 64'd0);
    check_eq({tag, "_valid"}, 64'(bus.result_valid), 64'd0);
    check_eq({tag, "_class"}, 64'(bus.result_class), 64'd0);
    check_eq({tag, "_fcnt"},  64'(bus.frame_count), 64'd0);
    check_eq({tag, "_err"},   64'(bus.error), 64'd0);
  endtask

  logic [W-1:0] fa [NN4] = '{47'd5, 47'd9, 47'd3, 47'd100, 47'd7, 47'd2, 47'd8, 47'd1, 47'd0, 47'd4};
  logic [W-1:0] fc [NN4] = '{47'd10, 47'd20, 47'd30, 47'd40, 47'd50, 47'd60, 47'd70, 47'd80, 47'd90, 47'd15};
  logic [W-1:0] fd [NN4] = '{47'd3, 47'd1, 47'd4, 47'd1, 47'd5, 47'd9, 47'd2, 47'd6, 47'd5, 47'd3};

  initial begin
    int starts;
    int first_err;
    int errs;
    int valids;

    reset            = 1'b1;
    mf_tie_low       = 1'b0;
    bus.wr_en        = 1'b0;
    bus.wr_addr      = 4'd0;
    bus.wr_data      = '0;
    bus.layer_done   = 1'b0;
    bus.result_ready = 1'b0;
    repeat (3) tick();
    check_all_zero("rst");
    reset = 1'b0;
    tick();

    // Nominal frame, cycle by cycle; argmax is index 3 (value 100).
    write_frame(fa, NN4);
    pulse_done();
    check_eq("t1_clear_mfra", 64'(bus.mf_reset_allowed), 64'd1);
    check_eq("t1_clear_start", 64'(bus.mf_start), 64'd0);
    check_eq("t1_clear_busy", 64'(bus.busy), 64'd1);
    for (int k = 0; k < NN4; k++) begin
      tick();
      check_eq("t1_stream_start", 64'(bus.mf_start), 64'd1);
      check_eq("t1_stream_mfra", 64'(bus.mf_reset_allowed), 64'd0);
      check_eq("t1_stream_data", 64'(bus.mf_data), 64'(fa[k]));
    end
    tick();
    check_eq("t1_wait_start", 64'(bus.mf_start), 64'd0);
    check_eq("t1_wait_hold", 64'(bus.mf_data), 64'd4);
    check_eq("t1_wait_valid", 64'(bus.result_valid), 64'd0);
    tick();
    check_eq("t1_valid_at_12", 64'(bus.result_valid), 64'd1);
    check_eq("t1_class", 64'(bus.result_class), 64'd3);
    handshake();
    check_eq("t1_valid_drop", 64'(bus.result_valid), 64'd0);
    check_eq("t1_fcnt", 64'(bus.frame_count), 64'd1);
    check_eq("t1_busy_idle", 64'(bus.busy), 64'd0);

    // Incomplete frame: addresses 0..8 only.
    write_frame(fc, NN4 - 1);
    pulse_done();
    check_eq("t2_err", 64'(bus.error), 64'd1);
    check_eq("t2_busy", 64'(bus.busy), 64'd0);
    starts = 0;
    tick();
    check_eq("t2_err_single", 64'(bus.error), 64'd0);
    for (int i = 0; i < 12; i++) begin
      if (bus.mf_start) starts++;
      tick();
    end
    check_eq("t2_no_start", 64'(starts), 64'd0);
    write_word(9, 47'd1);
    pulse_done();
    check_eq("t2_mask_cleared", 64'(bus.error), 64'd1);
    tick();

    // Stall in DONE; writes in CLEAR/DONE and layer_done in DONE are ignored.
    write_frame(fc, NN4);
    pulse_done();
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd9;
    bus.wr_data = 47'd500;
    tick();
    bus.wr_en   = 1'b0;
    wait_result("t3_latency", 1, 12);
    check_eq("t3_class", 64'(bus.result_class), 64'd8);
    for (int i = 0; i < 20; i++) begin
      bus.wr_en      = 1'b1;
      bus.wr_addr    = 4'(i % NN4);
      bus.wr_data    = 47'(1000 + i);
      bus.layer_done = (i == 5);
      tick();
      check_eq("t3_hold_valid", 64'(bus.result_valid), 64'd1);
      check_eq("t3_hold_class", 64'(bus.result_class), 64'd8);
    end
    bus.wr_en      = 1'b0;
    bus.layer_done = 1'b0;
    check_eq("t3_busy", 64'(bus.busy), 64'd1);
    handshake();
    check_eq("t3_fcnt", 64'(bus.frame_count), 64'd2);
    check_eq("t3_valid_drop", 64'(bus.result_valid), 64'd0);

    // max_finder never answers: error 4 cycles after WAIT entry (edge 15).
    mf_tie_low = 1'b1;
    write_frame(fa, NN4);
    pulse_done();
    first_err = 0;
    errs      = 0;
    valids    = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (bus.error && first_err == 0) first_err = n;
      if (bus.error) errs++;
      if (bus.result_valid) valids++;
    end
    check_eq("t4_err_edge", 64'(first_err), 64'd15);
    check_eq("t4_err_count", 64'(errs), 64'd1);
    check_eq("t4_no_valid", 64'(valids), 64'd0);
    check_eq("t4_busy", 64'(bus.busy), 64'd0);
    mf_tie_low = 1'b0;
    pulse_done();
    check_eq("t4_mask_cleared", 64'(bus.error), 64'd1);
    tick();

    // Reset mid-STREAM at ptr=5, then a clean frame (argmax 5, value 9).
    write_frame(fd, NN4);
    pulse_done();
    repeat (6) tick();
    check_eq("t5_ptr5_data", 64'(bus.mf_data), 64'd9);
    check_eq("t5_ptr5_start", 64'(bus.mf_start), 64'd1);
    reset = 1'b1;
    #1;
    check_all_zero("t5_rst");
    @(negedge clk);
    reset = 1'b0;
    tick();
    write_frame(fd, NN4);
    pulse_done();
    wait_result("t5_latency", 0, 12);
    check_eq("t5_class", 64'(bus.result_class), 64'd5);
    handshake();
    check_eq("t5_fcnt", 64'(bus.frame_count), 64'd1);

    // Preload the counter just below wrap, then one more frame.
    force dut.frame_count_r = 16'hFFFF;
    #1;
    release dut.frame_count_r;
    #1;
    check_eq("t6_preload", 64'(bus.frame_count), 64'hFFFF);
    tick();
    write_frame(fa, NN4);
    pulse_done();
    wait_result("t6_latency", 0, 12);
    check_eq("t6_class", 64'(bus.result_class), 64'd3);
    handshake();
    check_eq("t6_wrap", 64'(bus.frame_count), 64'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

endmodule

// File: doc/fnn_argmax_scheduler.md
# fnn_argmax_scheduler

Sequences the output-layer argmax stage of the FNN inference pipeline. Buffers the NN4 output-layer neuron values as the last layer writes them, then drives the `max_finder` datapath: a one-cycle clear, then one value per cycle. It waits for `found_max`, captures the predicted class and presents it to the downstream consumer with a valid/ready handshake. It sits between the layer-4 accumulator bank and the result/UART reporting logic.

## Interface
Parameters:
- INDATA_WIDTH, 47, width of each output-layer value; must equal the `max_finder` input width.
- NN4, 10, number of output neurons; must equal the `max_finder` terminal count (10); legal range 2..16.
- TIMEOUT_CYCLES, 4, WAIT-state cycles allowed before `error` fires.

Ports:
- clk  in  1  clock. Everything in this block runs on the rising edge. The `max_finder` samples on the falling edge, so its inputs are stable when it samples.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe from the output layer.
- wr_addr  in  4  neuron index, 0..NN4-1.
- wr_data  in  INDATA_WIDTH  neuron value.
- layer_done  in  1  single-cycle pulse from the output layer: frame complete.
- busy  out  1  high in every state except IDLE.
- mf_reset_allowed  out  1  drives `max_finder_reset_allowed`.
- mf_start  out  1  drives `start_maxfinder`.
- mf_data  out  INDATA_WIDTH  drives `input_data`.
- mf_found  in  1  from `found_max`.
- mf_index  in  4  from `predicted_output`.
- result_valid  out  1  result class available.
- result_class  out  4  argmax index, 0..NN4-1.
- result_ready  in  1  downstream accepts the result.
- frame_count  out  16  number of results accepted; wraps 0xFFFF -> 0.
- error  out  1  one-cycle pulse on an incomplete frame or a timeout.

## Operation
- Storage:
  - Buffer of NN4 x INDATA_WIDTH. The buffer is not reset.
  - Written-mask of NN4 bits, reset to 0.
- States: IDLE, CLEAR, STREAM, WAIT, DONE.
- IDLE:
  - wr_en writes buf[wr_addr] and sets mask[wr_addr].
  - wr_addr >= NN4 is ignored (no write, no mask change).
  - Rewriting the same address overwrites it.
  - On layer_done with mask all-ones: go to CLEAR.
  - On layer_done with mask incomplete: pulse `error`, clear the mask, stay in IDLE.
  - If wr_en and layer_done arrive in the same cycle, the write counts toward the mask before the completeness check.
- CLEAR (exactly 1 cycle):
  - mf_reset_allowed=1, mf_start=0.
  - Next state: STREAM with ptr=0.
- STREAM (exactly NN4 cycles):
  - mf_start=1, mf_data=buf[ptr], ptr increments by 1 per cycle.
  - After ptr=NN4-1: go to WAIT.
- WAIT:
  - mf_start=0, mf_data holds the last value.
  - When mf_found=1: latch result_class=mf_index and go to DONE.
  - After TIMEOUT_CYCLES cycles without mf_found: pulse `error`, clear the mask, go to IDLE.
- DONE:
  - result_valid=1 and result_class stays stable until result_ready=1.
  - On the handshake: frame_count+1, clear the mask, go to IDLE.
  - result_valid falls in the next cycle.
- wr_en and layer_done are ignored outside IDLE. Upstream must check `busy` before writing the next frame.
- mf_reset_allowed is high only in CLEAR. mf_start is high only in STREAM.

## Timing
- Reset values:
  - State IDLE.
  - busy, mf_reset_allowed, mf_start, result_valid, error = 0.
  - mf_data, result_class, frame_count, mask = 0.
- Reset mid-operation (any state) returns to IDLE immediately and discards any pending result. The `max_finder` is cleared by the next frame's CLEAR cycle.
- Latency, with layer_done sampled at edge E0:
  - CLEAR in cycle E0-E1.
  - STREAM values 0..NN4-1 in cycles E1..E(NN4+1).
  - WAIT entered at E(NN4+1).
  - With the nominal `max_finder`, mf_found is high by E(NN4+1), so result_valid rises at E(NN4+2). For NN4=10 that is 12 edges after layer_done.
- Throughput: one frame per NN4+3 cycles minimum (includes the DONE handshake and the return to IDLE), plus downstream stall cycles.
- error is a single-cycle pulse asserted in the cycle after the detecting edge.

## Test plan
- Write values 5,9,3,100,7,2,8,1,0,4 to addresses 0..9, then pulse layer_done -> mf_reset_allowed high for 1 cycle, mf_start high for 10 cycles with mf_data sequence matching the writes, result_class=3, result_valid 12 edges after layer_done, frame_count=1 after result_ready.
- Write only addresses 0..8, then pulse layer_done -> error pulse, state stays IDLE, busy=0, mf_start never asserts.
- Hold result_ready=0 for 20 cycles in DONE -> result_valid and result_class stay stable; wr_en writes during this window are ignored (buffer unchanged on the next frame's readback).
- Tie mf_found=0 -> error pulses exactly TIMEOUT_CYCLES=4 cycles after WAIT entry, then IDLE with mask cleared.
- Assert reset mid-STREAM at ptr=5 -> all outputs 0 at once; a new full frame then completes normally with the correct argmax.
- Preload frame_count to 0xFFFF by running frames, then complete one more -> frame_count wraps to 0x0000.
